qdr_port_arbiter: RTL and testbench
===================================

Name: qdr_port_arbiter

Overview:
Shares the single QDR-II+ controller user interface (one write and one read per clk_ram_ctl cycle) between NUM_PORTS ingress requesters, using independent round-robin arbitration on the write and read channels.
Sits between the per-port ingress FIFO logic and the BIST muxes, on the FIFO side of the mux.
Tracks outstanding reads in a tag FIFO and steers each returning word to the port that issued the read.

Parameters:
NUM_PORTS, 15, number of requesters.
ADDR_BITS, 18, RAM word address width.
DATA_BITS, 144, RAM word width (4 beats x 36 bits).
TAG_DEPTH, 16, maximum outstanding reads; power of 2, must be at least the controller round-trip latency in cycles.

Ports:
clk  in  1  clk_ram_ctl domain; all signals synchronous to it.
rst  in  1  synchronous, active-high reset.
wr_req  in  NUM_PORTS  per-port write request; held high until granted.
wr_addr  in  NUM_PORTS*ADDR_BITS  per-port write address; port i at [i*ADDR_BITS +: ADDR_BITS].
wr_data  in  NUM_PORTS*DATA_BITS  per-port write data, packed the same way.
wr_grant  out  NUM_PORTS  one-hot; the request was accepted this cycle.
rd_req  in  NUM_PORTS  per-port read request; held high until granted.
rd_addr  in  NUM_PORTS*ADDR_BITS  per-port read address.
rd_grant  out  NUM_PORTS  one-hot; the read was accepted this cycle.
ram_wr_en  out  1  to controller.
ram_wr_addr  out  ADDR_BITS  to controller.
ram_wr_data  out  DATA_BITS  to controller.
ram_rd_en  out  1  to controller.
ram_rd_addr  out  ADDR_BITS  to controller.
ram_rd_valid  in  1  read data return from controller.
ram_rd_data  in  DATA_BITS  read data from controller.
ret_valid  out  NUM_PORTS  one-hot; returned word belongs to this port.
ret_data  out  DATA_BITS  returned word, registered.
outstanding  out  $clog2(TAG_DEPTH+1)  current count of reads in flight.
tag_underflow  out  1  sticky; set when a return arrives with no outstanding tag.

Behaviour:
- Reset values: all grants low; ram_wr_en and ram_rd_en low; ram addresses and data zero; ret_valid zero; ret_data zero; outstanding 0; tag_underflow 0; both round-robin pointers 0; tag FIFO empty.
- Grant timing: grants are combinational from the req inputs and the pointer state, asserted in the same cycle as the request. At most one grant per channel per cycle.
- Round robin: each channel has a pointer p. Priority order is p, p+1, ..., wrapping modulo NUM_PORTS. After a grant to port g, p becomes (g+1) mod NUM_PORTS. With no grant, p holds.
- Write path: on wr_grant[g], the next cycle drives ram_wr_en=1, ram_wr_addr=wr_addr[g], ram_wr_data=wr_data[g] (1-cycle registered latency). Otherwise ram_wr_en=0 and address/data hold their last values.
- Read path: a read is granted only when outstanding < TAG_DEPTH.
  - On rd_grant[g], the next cycle drives ram_rd_en=1 and ram_rd_addr=rd_addr[g].
  - In the same grant cycle, index g is pushed into the tag FIFO and outstanding increments.
- Return path: on ram_rd_valid with the tag FIFO non-empty, pop tag t. The next cycle drives ret_valid one-hot at bit t and ret_data=ram_rd_data, and outstanding decrements.
- Underflow: ram_rd_valid with the tag FIFO empty discards the data, sets tag_underflow, and leaves ret_valid zero. tag_underflow clears only on rst.
- Simultaneous push and pop: both occur in the same cycle; outstanding is unchanged. When outstanding == TAG_DEPTH, a pop in a cycle does not enable a grant in that same cycle; the new grant happens the following cycle.
- Channel independence: the write and read channels arbitrate independently. One port may receive wr_grant and rd_grant in the same cycle.
- Reset mid-operation: the tag FIFO and counters are cleared. Returns still in flight in the controller afterwards hit the empty-FIFO case and set tag_underflow. Software quiesces traffic, and the BIST mux selects BIST, before resetting.
- Ordering: the controller returns reads in issue order, so a FIFO tag store is sufficient. No reordering logic is provided.

Test Plan:
1. Reset, then wr_req=15'h7FFF held for 30 cycles -> wr_grant sequence 0,1,...,14,0,... one per cycle; ram_wr_en high from cycle 2 with the address of the port granted in the previous cycle.
2. wr_req bits 3 and 9 only, pointer starting at 0 -> grants alternate 3,9,3,9; port 9 then drops and port 3 receives back-to-back grants.
3. rd_req on port 5 continuously, ram_rd_valid held off -> exactly 16 rd_grants, then the grant stalls with outstanding=16. One ram_rd_valid pulse -> ret_valid=1<<5 next cycle and one more grant the cycle after.
4. Interleaved reads from ports 2,7,2,11 with returns at a fixed latency of 6 cycles -> ret_valid = bit 2, 7, 2, 11 in order, each ret_data matching the injected data.
5. Same cycle: pop one tag and request a new read with outstanding=8 -> outstanding remains 8 and the push is recorded correctly.
6. ram_rd_valid with the tag FIFO empty -> tag_underflow=1 and ret_valid stays 0; assert rst with reads outstanding -> outstanding=0 and a late return sets tag_underflow.

Source files
------------

// File: rtl/qdr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : qdr_port_arbiter
//  Description : Shares one QDR-II+ controller user interface between
//                NUM_PORTS requesters. The write and read channels each have
//                their own round-robin arbiter. A tag FIFO records the issuing
//                port of every read so that returning words are steered back
//                to the requester that issued them.
//  Revision    : 1.0 - initial release
// ============================================================================
module qdr_port_arbiter #(
    parameter int NUM_PORTS = 15,
    parameter int ADDR_BITS = 18,
    parameter int DATA_BITS = 144,
    parameter int TAG_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           wr_req,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] wr_addr,
    input  logic [NUM_PORTS*DATA_BITS-1:0] wr_data,
    output logic [NUM_PORTS-1:0]           wr_grant,
    input  logic [NUM_PORTS-1:0]           rd_req,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] rd_addr,
    output logic [NUM_PORTS-1:0]           rd_grant,
    output logic                           ram_wr_en,
    output logic [ADDR_BITS-1:0]           ram_wr_addr,
    output logic [DATA_BITS-1:0]           ram_wr_data,
    output logic                           ram_rd_en,
    output logic [ADDR_BITS-1:0]           ram_rd_addr,
    input  logic                           ram_rd_valid,
    input  logic [DATA_BITS-1:0]           ram_rd_data,
    output logic [NUM_PORTS-1:0]           ret_valid,
    output logic [DATA_BITS-1:0]           ret_data,
    output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
    output logic                           tag_underflow
);

    localparam int c_PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_TAG_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(TAG_DEPTH + 1);
    localparam logic [c_PORT_W-1:0]  c_LAST_PORT = c_PORT_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] c_ONE_HOT0  = NUM_PORTS'(1);

    // Per-port views of the packed address/data buses
    logic [ADDR_BITS-1:0] w_wr_addr_arr [NUM_PORTS];
    logic [DATA_BITS-1:0] w_wr_data_arr [NUM_PORTS];
    logic [ADDR_BITS-1:0] w_rd_addr_arr [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign w_wr_addr_arr[gi] = wr_addr[gi*ADDR_BITS +: ADDR_BITS];
        assign w_wr_data_arr[gi] = wr_data[gi*DATA_BITS +: DATA_BITS];
        assign w_rd_addr_arr[gi] = rd_addr[gi*ADDR_BITS +: ADDR_BITS];
    end

    // Returns {found, index} of the first requester at or after ptr, wrapping.
    function automatic logic [c_PORT_W:0] f_rr_pick(
        input logic [NUM_PORTS-1:0] req,
        input logic [c_PORT_W-1:0]  ptr
    );
        logic [c_PORT_W:0]   res;
        logic [c_PORT_W-1:0] idx;
        int                  i;
        res = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            i   = (int'(ptr) + k) % NUM_PORTS;
            idx = c_PORT_W'(i);
            if (!res[c_PORT_W] && req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Registered state
    logic [c_PORT_W-1:0]  r_wr_ptr_q,        w_wr_ptr_d;
    logic [c_PORT_W-1:0]  r_rd_ptr_q,        w_rd_ptr_d;
    logic                 r_ram_wr_en_q,     w_ram_wr_en_d;
    logic [ADDR_BITS-1:0] r_ram_wr_addr_q,   w_ram_wr_addr_d;
    logic [DATA_BITS-1:0] r_ram_wr_data_q,   w_ram_wr_data_d;
    logic                 r_ram_rd_en_q,     w_ram_rd_en_d;
    logic [ADDR_BITS-1:0] r_ram_rd_addr_q,   w_ram_rd_addr_d;
    logic [NUM_PORTS-1:0] r_ret_valid_q,     w_ret_valid_d;
    logic [DATA_BITS-1:0] r_ret_data_q,      w_ret_data_d;
    logic [c_CNT_W-1:0]   r_outstanding_q,   w_outstanding_d;
    logic                 r_tag_underflow_q, w_tag_underflow_d;
    logic [c_TAG_W-1:0]   r_tag_wptr_q,      w_tag_wptr_d;
    logic [c_TAG_W-1:0]   r_tag_rptr_q,      w_tag_rptr_d;
    logic [c_PORT_W-1:0]  r_tag_mem [TAG_DEPTH];

    // Arbitration results
    logic [c_PORT_W:0]   w_wr_pick;
    logic [c_PORT_W:0]   w_rd_pick;
    logic                w_wr_found;
    logic                w_rd_found;
    logic                w_rd_allow;
    logic [c_PORT_W-1:0] w_wr_idx;
    logic [c_PORT_W-1:0] w_rd_idx;
    logic                w_push;
    logic                w_pop;
    logic                w_underflow;

    // Combinational grants; reads are held off while the tag store is full
    always_comb begin
        w_wr_pick  = f_rr_pick(wr_req, r_wr_ptr_q);
        w_rd_pick  = f_rr_pick(rd_req, r_rd_ptr_q);
        // Uses the registered count so a same-cycle pop never frees a slot early
        w_rd_allow = (r_outstanding_q < c_CNT_W'(TAG_DEPTH));
        w_wr_found = w_wr_pick[c_PORT_W];
        w_wr_idx   = w_wr_pick[c_PORT_W-1:0];
        w_rd_found = w_rd_pick[c_PORT_W] & w_rd_allow;
        w_rd_idx   = w_rd_pick[c_PORT_W-1:0];
        wr_grant   = w_wr_found ? (c_ONE_HOT0 << w_wr_idx) : '0;
        rd_grant   = w_rd_found ? (c_ONE_HOT0 << w_rd_idx) : '0;
    end

    // Next-state for pointers, controller interface, tag FIFO and return path
    always_comb begin
        w_wr_ptr_d        = r_wr_ptr_q;
        w_rd_ptr_d        = r_rd_ptr_q;
        w_ram_wr_en_d     = w_wr_found;
        w_ram_wr_addr_d   = r_ram_wr_addr_q;
        w_ram_wr_data_d   = r_ram_wr_data_q;
        w_ram_rd_en_d     = w_rd_found;
        w_ram_rd_addr_d   = r_ram_rd_addr_q;
        w_push            = w_rd_found;
        w_pop             = ram_rd_valid && (r_outstanding_q != '0);
        w_underflow       = ram_rd_valid && (r_outstanding_q == '0);
        w_tag_wptr_d      = r_tag_wptr_q;
        w_tag_rptr_d      = r_tag_rptr_q;
        w_outstanding_d   = r_outstanding_q;
        w_ret_valid_d     = '0;
        w_ret_data_d      = r_ret_data_q;
        w_tag_underflow_d = r_tag_underflow_q | w_underflow;

        if (w_wr_found) begin
            w_wr_ptr_d      = (w_wr_idx == c_LAST_PORT) ? '0 : w_wr_idx + c_PORT_W'(1);
            w_ram_wr_addr_d = w_wr_addr_arr[w_wr_idx];
            w_ram_wr_data_d = w_wr_data_arr[w_wr_idx];
        end

        if (w_rd_found) begin
            w_rd_ptr_d      = (w_rd_idx == c_LAST_PORT) ? '0 : w_rd_idx + c_PORT_W'(1);
            w_ram_rd_addr_d = w_rd_addr_arr[w_rd_idx];
        end

        if (w_push) begin
            w_tag_wptr_d = r_tag_wptr_q + c_TAG_W'(1);
        end

        if (w_pop) begin
            w_tag_rptr_d  = r_tag_rptr_q + c_TAG_W'(1);
            w_ret_valid_d = c_ONE_HOT0 << r_tag_mem[r_tag_rptr_q];
            w_ret_data_d  = ram_rd_data;
        end

        case ({w_push, w_pop})
            2'b10:   w_outstanding_d = r_outstanding_q + c_CNT_W'(1);
            2'b01:   w_outstanding_d = r_outstanding_q - c_CNT_W'(1);
            default: w_outstanding_d = r_outstanding_q;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q        <= '0;
            r_rd_ptr_q        <= '0;
            r_ram_wr_en_q     <= 1'b0;
            r_ram_wr_addr_q   <= '0;
            r_ram_wr_data_q   <= '0;
            r_ram_rd_en_q     <= 1'b0;
            r_ram_rd_addr_q   <= '0;
            r_ret_valid_q     <= '0;
            r_ret_data_q      <= '0;
            r_outstanding_q   <= '0;
            r_tag_underflow_q <= 1'b0;
            r_tag_wptr_q      <= '0;
            r_tag_rptr_q      <= '0;
        end else begin
            r_wr_ptr_q        <= w_wr_ptr_d;
            r_rd_ptr_q        <= w_rd_ptr_d;
            r_ram_wr_en_q     <= w_ram_wr_en_d;
            r_ram_wr_addr_q   <= w_ram_wr_addr_d;
            r_ram_wr_data_q   <= w_ram_wr_data_d;
            r_ram_rd_en_q     <= w_ram_rd_en_d;
            r_ram_rd_addr_q   <= w_ram_rd_addr_d;
            r_ret_valid_q     <= w_ret_valid_d;
            r_ret_data_q      <= w_ret_data_d;
            r_outstanding_q   <= w_outstanding_d;
            r_tag_underflow_q <= w_tag_underflow_d;
            r_tag_wptr_q      <= w_tag_wptr_d;
            r_tag_rptr_q      <= w_tag_rptr_d;
        end
    end

    // Tag storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_tag_mem[r_tag_wptr_q] <= w_rd_idx;
        end
    end

    assign ram_wr_en     = r_ram_wr_en_q;
    assign ram_wr_addr   = r_ram_wr_addr_q;
    assign ram_wr_data   = r_ram_wr_data_q;
    assign ram_rd_en     = r_ram_rd_en_q;
    assign ram_rd_addr   = r_ram_rd_addr_q;
    assign ret_valid     = r_ret_valid_q;
    assign ret_data      = r_ret_data_q;
    assign outstanding   = r_outstanding_q;
    assign tag_underflow = r_tag_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_qdr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qdr_port_arbiter
//  Description : Scoreboard bench for qdr_port_arbiter. A driver applies
//                directed and random traffic and a behavioural model predicts
//                grants and registered responses; a monitor pops predictions
//                whenever the DUT presents a controller command or a return.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qdr_port_arbiter;

    localparam int N  = 15;
    localparam int A  = 18;
    localparam int D  = 144;
    localparam int TD = 16;
    localparam int CW = $clog2(TD + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     wr_req = '0;
    logic [N*A-1:0]   wr_addr = '0;
    logic [N*D-1:0]   wr_data = '0;
    logic [N-1:0]     wr_grant;
    logic [N-1:0]     rd_req = '0;
    logic [N*A-1:0]   rd_addr = '0;
    logic [N-1:0]     rd_grant;
    logic             ram_wr_en;
    logic [A-1:0]     ram_wr_addr;
    logic [D-1:0]     ram_wr_data;
    logic             ram_rd_en;
    logic [A-1:0]     ram_rd_addr;
    logic             ram_rd_valid = 1'b0;
    logic [D-1:0]     ram_rd_data = '0;
    logic [N-1:0]     ret_valid;
    logic [D-1:0]     ret_data;
    logic [CW-1:0]    outstanding;
    logic             tag_underflow;

    qdr_port_arbiter #(.NUM_PORTS(N), .ADDR_BITS(A), .DATA_BITS(D), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
        .ram_rd_valid(ram_rd_valid), .ram_rd_data(ram_rd_data),
        .ret_valid(ret_valid), .ret_data(ret_data),
        .outstanding(outstanding), .tag_underflow(tag_underflow)
    );

    always #5 clk = ~clk;

    typedef struct { logic [A-1:0] addr; logic [D-1:0] data; } wr_t;
    typedef struct { int port; logic [D-1:0] data; } ret_t;

    // Reference model state
    int           m_wptr = 0;
    int           m_rptr = 0;
    int           tags[$];
    int           exp_out = 0;
    bit           exp_uf  = 1'b0;
    wr_t          exp_wr[$];
    logic [A-1:0] exp_rd[$];
    ret_t         exp_ret[$];
    int           ctl_due[$];      // controller emulation: cycle each read returns

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    bit           mon_en   = 1'b0;
    bit           auto_ret = 1'b1;
    int           ret_lat  = 6;
    logic [N-1:0] last_wr_grant;
    logic [N-1:0] last_rd_grant;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [D-1:0] rand_data();
        logic [D-1:0] v;
        v = '0;
        for (int i = 0; i < 5; i++) v = (v << 32) | D'($urandom);
        return v;
    endfunction

    // First requester at or after p in circular order, -1 if none
    function automatic int rr_pick(input logic [N-1:0] req, input int p);
        int i;
        for (int k = 0; k < N; k++) begin
            i = (p + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Predict this cycle's grants and the responses they cause next cycle
    task automatic model_step();
        int   wg, rg, t;
        wr_t  w;
        ret_t r;
        wg = rr_pick(wr_req, m_wptr);
        rg = (tags.size() < TD) ? rr_pick(rd_req, m_rptr) : -1;
        chk("wr_grant", wr_grant, onehot(wg));
        chk("rd_grant", rd_grant, onehot(rg));
        last_wr_grant = wr_grant;
        last_rd_grant = rd_grant;
        if (rst) begin
            m_wptr = 0; m_rptr = 0; tags.delete(); exp_uf = 1'b0; exp_out = 0;
        end else begin
            if (wg >= 0) begin
                w.addr = wr_addr[wg*A +: A];
                w.data = wr_data[wg*D +: D];
                exp_wr.push_back(w);
                m_wptr = (wg + 1) % N;
            end
            if (ram_rd_valid) begin
                if (tags.size() > 0) begin
                    t = tags.pop_front();
                    r.port = t;
                    r.data = ram_rd_data;
                    exp_ret.push_back(r);
                end else begin
                    exp_uf = 1'b1;
                end
            end
            if (rg >= 0) begin
                exp_rd.push_back(rd_addr[rg*A +: A]);
                tags.push_back(rg);
                ctl_due.push_back(cyc + 1 + ret_lat);
                m_rptr = (rg + 1) % N;
            end
            exp_out = tags.size();
        end
    endtask

    // One clock: drive inputs after the edge, evaluate the model at mid-cycle
    task automatic tick(input logic [N-1:0] wq, input logic [N-1:0] rq, input bit pulse, input bit do_rst);
        @(posedge clk);
        #1;
        cyc++;
        rst    = do_rst;
        wr_req = wq;
        rd_req = rq;
        for (int p = 0; p < N; p++) begin
            wr_addr[p*A +: A] = A'($urandom);
            rd_addr[p*A +: A] = A'($urandom);
            wr_data[p*D +: D] = rand_data();
        end
        ram_rd_valid = 1'b0;
        ram_rd_data  = rand_data();
        if (pulse) begin
            ram_rd_valid = 1'b1;
            if (ctl_due.size() > 0) void'(ctl_due.pop_front());
        end else if (auto_ret && ctl_due.size() > 0 && ctl_due[0] <= cyc) begin
            ram_rd_valid = 1'b1;
            void'(ctl_due.pop_front());
        end
        @(negedge clk);
        model_step();
    endtask

    task automatic drain();
        auto_ret = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (ctl_due.size() == 0) break;
            tick('0, '0, 1'b0, 1'b0);
        end
        tick('0, '0, 1'b0, 1'b0);
        tick('0, '0, 1'b0, 1'b0);
        chk("drain_pending", ctl_due.size(), 0);
    endtask

    // Monitor: registered outputs checked against the oldest prediction
    always @(posedge clk) begin
        wr_t          w;
        logic [A-1:0] ra;
        ret_t         r;
        #2;
        if (mon_en) begin
            chk("ram_wr_en", ram_wr_en, exp_wr.size() != 0);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                if (ram_wr_en) begin
                    chk("ram_wr_addr", ram_wr_addr, w.addr);
                    chk("ram_wr_data", ram_wr_data, w.data);
                end
            end
            chk("ram_rd_en", ram_rd_en, exp_rd.size() != 0);
            if (exp_rd.size() != 0) begin
                ra = exp_rd.pop_front();
                if (ram_rd_en) chk("ram_rd_addr", ram_rd_addr, ra);
            end
            chk("ret_any", |ret_valid, exp_ret.size() != 0);
            if (exp_ret.size() != 0) begin
                r = exp_ret.pop_front();
                chk("ret_valid", ret_valid, onehot(r.port));
                chk("ret_data", ret_data, r.data);
            end
            chk("outstanding", outstanding, exp_out);
            chk("tag_underflow", tag_underflow, exp_uf);
        end
    end

    initial begin
        int cnt;
        tick('0, '0, 1'b0, 1'b1);
        tick('0, '0, 1'b0, 1'b1);
        mon_en = 1'b1;
        tick('0, '0, 1'b0, 1'b0);
        // Reset state
        chk("rst_ram_wr_addr", ram_wr_addr, 0);
        chk("rst_ram_wr_data", ram_wr_data, 0);
        chk("rst_ram_rd_addr", ram_rd_addr, 0);
        chk("rst_ret_data", ret_data, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_tag_underflow", tag_underflow, 0);

        // All ports writing: grants rotate 0..14
        for (int i = 0; i < 30; i++) begin
            tick(15'h7FFF, '0, 1'b0, 1'b0);
            chk("wr_rotate", last_wr_grant, onehot(i % N));
        end

        // Two writers alternate, then one gets back-to-back grants
        for (int i = 0; i < 4; i++) tick(15'h0208, '0, 1'b0, 1'b0);
        tick(15'h0008, '0, 1'b0, 1'b0);
        tick(15'h0008, '0, 1'b0, 1'b0);
        chk("wr_back_to_back", last_wr_grant, onehot(3));

        // Read stall at full tag store, released by one return
        auto_ret = 1'b0;
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            tick('0, onehot(5), 1'b0, 1'b0);
            if (last_rd_grant[5]) cnt++;
        end
        chk("rd_grants_to_full", cnt, TD);
        chk("outstanding_full", outstanding, TD);
        tick('0, onehot(5), 1'b1, 1'b0);
        chk("no_grant_on_pop", last_rd_grant, 0);
        tick('0, onehot(5), 1'b0, 1'b0);
        chk("grant_after_pop", last_rd_grant, onehot(5));
        chk("ret_port5", ret_valid, onehot(5));
        drain();

        // Interleaved ports with fixed return latency
        ret_lat = 6;
        tick('0, onehot(2), 1'b0, 1'b0);
        tick('0, onehot(7), 1'b0, 1'b0);
        tick('0, onehot(2), 1'b0, 1'b0);
        tick('0, onehot(11), 1'b0, 1'b0);
        drain();

        // Simultaneous push and pop at outstanding 8
        auto_ret = 1'b0;
        for (int i = 0; i < 8; i++) tick('0, onehot(4), 1'b0, 1'b0);
        tick('0, onehot(6), 1'b1, 1'b0);
        tick('0, '0, 1'b0, 1'b0);
        chk("push_pop_outstanding", outstanding, 8);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ret_lat = 6;
            tick(N'($urandom) & N'($urandom), N'($urandom) & N'($urandom), 1'b0, 1'b0);
        end
        drain();

        // Underflow on empty return, then reset with reads in flight
        tick('0, '0, 1'b1, 1'b0);
        tick('0, '0, 1'b0, 1'b0);
        chk("underflow_set", tag_underflow, 1);
        auto_ret = 1'b0;
        for (int i = 0; i < 3; i++) tick('0, onehot(1), 1'b0, 1'b0);
        tick('0, '0, 1'b0, 1'b1);
        tick('0, '0, 1'b0, 1'b0);
        chk("reset_outstanding", outstanding, 0);
        chk("reset_underflow_clear", tag_underflow, 0);
        drain();
        chk("late_return_underflow", tag_underflow, 1);

        tick('0, '0, 1'b0, 1'b0);
        mon_en = 1'b0;
        chk("exp_queues_empty", exp_wr.size() + exp_rd.size() + exp_ret.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
